// File: rtl/pkt_arbiter4.sv
// Four-port round-robin packet arbiter. Grants one requester per packet
// (header plus N payload flits) and drives a single registered output port.
module pkt_arbiter4 #(
    parameter int unsigned W = 64
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [4*W-1:0] D,
    input  logic [3:0]     D_VALID,
    output logic [3:0]     D_BP,
    output logic [W-1:0]   Q,
    output logic           Q_VALID,
    input  logic           Q_BP,
    output logic           Q_SOF,
    output logic [3:0]     GRANT
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [3:0]   grant_q, grant_d;
    logic [1:0]   sel_q, sel_d;
    logic [1:0]   last_q, last_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         hdr_q, hdr_d;
    logic [W-1:0] q_q, q_d;
    logic         q_valid_q, q_valid_d;
    logic         q_sof_q, q_sof_d;

    logic         out_ready;
    logic         xfer;
    logic         last_flit;
    logic [W-1:0] sel_flit;
    logic [1:0]   pick;
    logic [1:0]   cand;
    logic         found;

    // The output register can take a new flit when empty or draining this cycle.
    assign out_ready = !q_valid_q || !Q_BP;
    assign xfer      = (state_q == StBusy) && out_ready && D_VALID[sel_q];
    assign last_flit = hdr_q ? (sel_flit[7:0] == 8'd0) : (cnt_q == 8'd1);

    always_comb begin
        sel_flit = '0;
        for (int i = 0; i < 4; i++) begin
            if (grant_q[i]) begin
                sel_flit = D[i*W +: W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            D_BP[i] = !((state_q == StBusy) && grant_q[i] && out_ready);
        end
    end

    // Round-robin search starting one past the last granted port.
    always_comb begin
        pick  = last_q;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && D_VALID[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StBusy;
                    grant_d = 4'b0001 << pick;
                    sel_d   = pick;
                    hdr_d   = 1'b1;
                end
            end
            StBusy: begin
                if (xfer) begin
                    if (hdr_q) begin
                        cnt_d = sel_flit[7:0];
                        hdr_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                    if (last_flit) begin
                        state_d = StIdle;
                        grant_d = 4'b0000;
                        last_d  = sel_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_comb begin
        q_d       = q_q;
        q_valid_d = q_valid_q;
        q_sof_d   = q_sof_q;
        if (xfer) begin
            q_d       = sel_flit;
            q_valid_d = 1'b1;
            q_sof_d   = hdr_q;
        end else if (q_valid_q && !Q_BP) begin
            q_valid_d = 1'b0;
            q_sof_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            grant_q   <= 4'b0000;
            sel_q     <= 2'd0;
            last_q    <= 2'd3;
            cnt_q     <= 8'd0;
            hdr_q     <= 1'b0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            q_sof_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            hdr_q     <= hdr_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            q_sof_q   <= q_sof_d;
        end
    end

    assign GRANT   = grant_q;
    assign Q       = q_q;
    assign Q_VALID = q_valid_q;
    assign Q_SOF   = q_sof_q;

endmodule

// File: tb/tb_pkt_arbiter4.sv
// Directed bench for pkt_arbiter4: single-port packet, round-robin order,
// output stall, mid-packet contention and mid-packet reset.
module tb_pkt_arbiter4;

    localparam int W = 64;

    logic           CLK;
    logic           RST;
    logic [4*W-1:0] D;
    logic [3:0]     D_VALID;
    logic [3:0]     D_BP;
    logic [W-1:0]   Q;
    logic           Q_VALID;
    logic           Q_BP;
    logic           Q_SOF;
    logic [3:0]     GRANT;

    int n_cmp = 0;
    int n_err = 0;

    logic [W:0] q_log [$];
    logic [3:0] g_exp [9];

    pkt_arbiter4 #(.W(W)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .D       (D),
        .D_VALID (D_VALID),
        .D_BP    (D_BP),
        .Q       (Q),
        .Q_VALID (Q_VALID),
        .Q_BP    (Q_BP),
        .Q_SOF   (Q_SOF),
        .GRANT   (GRANT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Record every flit the downstream consumes, tagged with its SOF bit.
    always @(negedge CLK) begin
        if (!RST && Q_VALID && !Q_BP) begin
            q_log.push_back({Q_SOF, Q});
        end
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [W-1:0] mk_flit(input int p, input logic [47:0] tag,
                                             input int idx, input int n);
        if (idx == 0) begin
            return {tag, 8'(p), 8'(n)};
        end
        return {tag ^ 48'hFFFF_0000_0000, 8'(p), 8'(idx)};
    endfunction

    task automatic do_reset();
        RST     = 1'b1;
        D       = '0;
        D_VALID = 4'b0000;
        Q_BP    = 1'b0;
        step();
        step();
        check("rst_grant", 64'(GRANT), 64'h0);
        check("rst_d_bp", 64'(D_BP), 64'hF);
        check("rst_q_valid", 64'(Q_VALID), 64'h0);
        check("rst_q_sof", 64'(Q_SOF), 64'h0);
        check("rst_q", Q, 64'h0);
        RST = 1'b0;
    endtask

    // Present one packet on port p, advancing a flit on every accepted cycle.
    task automatic send_pkt(input int p, input int n, input logic [47:0] tag);
        int sent;
        int budget;
        sent   = 0;
        budget = 100;
        D[W*p +: W] = mk_flit(p, tag, 0, n);
        D_VALID[p]  = 1'b1;
        while (sent <= n && budget > 0) begin
            #1;
            if (!D_BP[p]) sent++;
            step();
            budget--;
            if (sent <= n) D[W*p +: W] = mk_flit(p, tag, sent, n);
            else D_VALID[p] = 1'b0;
        end
        check("send_done", 64'(budget > 0), 64'd1);
    endtask

    initial begin
        logic [47:0] t;
        int          wait_n;

        // Single requester on port 2, N=2.
        do_reset();
        t = 48'hA2A2_0000_0001;
        D[W*2 +: W] = mk_flit(2, t, 0, 2);
        D_VALID     = 4'b0100;
        #1 check("p2_idle_bp", 64'(D_BP), 64'hF);
        step();
        check("p2_grant", 64'(GRANT), 64'h4);
        #1 check("p2_bp", 64'(D_BP), 64'hB);
        step();
        check("p2_q_hdr", Q, mk_flit(2, t, 0, 2));
        check("p2_sof_hdr", 64'({Q_VALID, Q_SOF}), 64'h3);
        D[W*2 +: W] = mk_flit(2, t, 1, 2);
        step();
        check("p2_q_pl1", Q, mk_flit(2, t, 1, 2));
        check("p2_sof_pl1", 64'({Q_VALID, Q_SOF}), 64'h2);
        D[W*2 +: W] = mk_flit(2, t, 2, 2);
        step();
        check("p2_q_pl2", Q, mk_flit(2, t, 2, 2));
        check("p2_sof_pl2", 64'({Q_VALID, Q_SOF}), 64'h2);
        check("p2_grant_end", 64'(GRANT), 64'h0);
        D_VALID = 4'b0000;
        step();
        check("p2_q_valid_end", 64'(Q_VALID), 64'h0);

        // All ports valid with single-flit packets: grant order 0,1,2,3,0.
        do_reset();
        t = 48'hC0DE_0000_0000;
        for (int p = 0; p < 4; p++) D[W*p +: W] = mk_flit(p, t, 0, 0);
        D_VALID = 4'b1111;
        g_exp[0] = 4'b0001; g_exp[1] = 4'b0000; g_exp[2] = 4'b0010;
        g_exp[3] = 4'b0000; g_exp[4] = 4'b0100; g_exp[5] = 4'b0000;
        g_exp[6] = 4'b1000; g_exp[7] = 4'b0000; g_exp[8] = 4'b0001;
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("rr_grant_c%0d", k), 64'(GRANT), 64'(g_exp[k-1]));
            check($sformatf("rr_qv_c%0d", k), 64'(Q_VALID), 64'((k % 2) == 0));
            if ((k % 2) == 0) check($sformatf("rr_q_c%0d", k), Q, mk_flit(k/2 - 1, t, 0, 0));
        end

        // Port 1, N=3, downstream stalls for 5 cycles on the header.
        do_reset();
        q_log.delete();
        t = 48'hB1B1_0000_0003;
        fork
            send_pkt(1, 3, t);
            begin
                wait_n = 0;
                while (!Q_VALID && wait_n < 20) begin
                    step();
                    wait_n++;
                end
                check("stall_q_seen", 64'(Q_VALID), 64'h1);
                Q_BP = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    #1;
                    check($sformatf("stall_q_%0d", i), Q, mk_flit(1, t, 0, 3));
                    check($sformatf("stall_flags_%0d", i), 64'({Q_VALID, Q_SOF}), 64'h3);
                    check($sformatf("stall_bp1_%0d", i), 64'(D_BP[1]), 64'h1);
                    step();
                end
                Q_BP = 1'b0;
            end
        join
        step();
        step();
        check("stall_count", 64'(q_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_log.size())
                check($sformatf("stall_flit_%0d", i), 64'(q_log[i][W-1:0]), mk_flit(1, t, i, 3));
            if (i < q_log.size())
                check($sformatf("stall_sof_%0d", i), 64'(q_log[i][W]), 64'(i == 0));
        end

        // Port 0 N=2, drops valid for a cycle; port 3 arrives mid-packet.
        do_reset();
        t = 48'h0303_0000_0002;
        D[W*0 +: W] = mk_flit(0, t, 0, 2);
        D_VALID     = 4'b0001;
        step();
        check("mid_grant0", 64'(GRANT), 64'h1);
        step();
        D_VALID     = 4'b1000;
        D[W*3 +: W] = mk_flit(3, t, 0, 0);
        #1 check("mid_bp3_a", 64'(D_BP[3]), 64'h1);
        step();
        check("mid_grant_kept", 64'(GRANT), 64'h1);
        D_VALID     = 4'b1001;
        D[W*0 +: W] = mk_flit(0, t, 1, 2);
        #1 check("mid_bp3_b", 64'(D_BP[3]), 64'h1);
        step();
        check("mid_q_pl1", Q, mk_flit(0, t, 1, 2));
        D[W*0 +: W] = mk_flit(0, t, 2, 2);
        #1 check("mid_bp3_c", 64'(D_BP[3]), 64'h1);
        step();
        check("mid_grant_end", 64'(GRANT), 64'h0);
        D_VALID = 4'b1000;
        #1 check("mid_bp_idle", 64'(D_BP), 64'hF);
        step();
        check("mid_grant3", 64'(GRANT), 64'h8);
        #1 check("mid_bp3_open", 64'(D_BP), 64'h7);
        step();
        check("mid_q_hdr3", Q, mk_flit(3, t, 0, 0));
        check("mid_sof3", 64'(Q_SOF), 64'h1);
        D_VALID = 4'b0000;

        // Reset during the 2nd payload of an N=4 packet on port 0.
        do_reset();
        t = 48'h4444_0000_0004;
        D[W*0 +: W] = mk_flit(0, t, 0, 4);
        D_VALID     = 4'b0001;
        step();
        step();
        D[W*0 +: W] = mk_flit(0, t, 1, 4);
        step();
        D[W*0 +: W] = mk_flit(0, t, 2, 4);
        check("rp_q_pl1", Q, mk_flit(0, t, 1, 4));
        RST = 1'b1;
        #1;
        check("rp_grant", 64'(GRANT), 64'h0);
        check("rp_d_bp", 64'(D_BP), 64'hF);
        check("rp_qv_sof", 64'({Q_VALID, Q_SOF}), 64'h0);
        check("rp_q", Q, 64'h0);
        D_VALID = 4'b0000;
        step();
        RST = 1'b0;
        q_log.delete();
        D[W*3 +: W] = mk_flit(3, t, 0, 0);
        D_VALID     = 4'b1000;
        step();
        check("rp_grant3", 64'(GRANT), 64'h8);
        step();
        D_VALID = 4'b0000;
        step();
        check("rp_log_count", 64'(q_log.size()), 64'd1);
        if (q_log.size() > 0) check("rp_log_flit", 64'(q_log[0][W-1:0]), mk_flit(3, t, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
